// File: rtl/dog_pkg.sv
// -----------------------------------------------------------------------------
// dog_pkg
// Shared definitions for the hunting-dog sprite sequencer:
//   - POS_W        : width of sprite x/y positions
//   - SEL_W        : width of the dog ROM sprite index
//   - CNT_W/N_CNT  : frame-tick counter width and number of timing counters
//   - CNT_*        : index of each timing counter (step, sniff, hold)
//   - dog_state_t  : sequencer state encoding
//   - DOG_*        : sprite index constants understood by the dog ROM
//   - next_walk()  : walk-cycle sprite successor (0->1->2->3->0)
// -----------------------------------------------------------------------------
package dog_pkg;

    localparam int POS_W = 11;
    localparam int SEL_W = 4;
    localparam int CNT_W = 8;

    localparam int N_CNT     = 3;
    localparam int CNT_STEP  = 0;
    localparam int CNT_SNIFF = 1;
    localparam int CNT_HOLD  = 2;

    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_WALK      = 4'd1,
        ST_SNIFF     = 4'd2,
        ST_JUMP_UP   = 4'd3,
        ST_JUMP_DOWN = 4'd4,
        ST_HIDDEN    = 4'd5,
        ST_CATCH_UP  = 4'd6,
        ST_LAUGH_UP  = 4'd7,
        ST_HOLD      = 4'd8,
        ST_DOWN      = 4'd9
    } dog_state_t;

    localparam logic [SEL_W-1:0] DOG_WALK0     = 4'd0;
    localparam logic [SEL_W-1:0] DOG_WALK1     = 4'd1;
    localparam logic [SEL_W-1:0] DOG_WALK2     = 4'd2;
    localparam logic [SEL_W-1:0] DOG_WALK3     = 4'd3;
    localparam logic [SEL_W-1:0] DOG_SNIFF     = 4'd4;
    localparam logic [SEL_W-1:0] DOG_JUMP_UP   = 4'd5;
    localparam logic [SEL_W-1:0] DOG_JUMP_DOWN = 4'd6;
    localparam logic [SEL_W-1:0] DOG_HOLD      = 4'd7;
    localparam logic [SEL_W-1:0] DOG_LAUGH     = 4'd8;

    // Walk cycle wraps after the fourth frame back to the first.
    function automatic logic [SEL_W-1:0] next_walk(input logic [SEL_W-1:0] sel);
        return (sel == DOG_WALK3) ? DOG_WALK0 : sel + SEL_W'(1);
    endfunction

endpackage

// File: rtl/dog_tick_cnt.sv
// -----------------------------------------------------------------------------
// dog_tick_cnt
// Frame-tick driven counter with synchronous clear and terminal-count compare.
// Counts tick pulses 0..TERM-1 and wraps; 'hit' is high in the cycle of the
// TERM-th tick since the last clear.
// Ports:
//   clk   in  clock
//   rst   in  asynchronous active-high reset
//   clr   in  synchronous clear (wins over tick)
//   tick  in  count enable (already gated with the owning state)
//   hit   out tick arriving while at terminal count (combinational)
// -----------------------------------------------------------------------------
module dog_tick_cnt #(
    parameter int WIDTH = 8,
    parameter int TERM  = 6
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic tick,
    output logic hit
);

    logic [WIDTH-1:0] count_reg;
    logic             at_term;

    assign at_term = (count_reg == WIDTH'(TERM - 1));
    assign hit     = tick & at_term;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_reg <= '0;
        end else if (clr) begin
            count_reg <= '0;
        end else if (tick) begin
            count_reg <= at_term ? '0 : count_reg + WIDTH'(1);
        end
    end

endmodule

// File: rtl/dog_ctl.sv
// -----------------------------------------------------------------------------
// dog_ctl
// Hunting-dog sprite sequencer. Runs the intro walk/sniff/jump and the catch /
// laugh pop-ups behind the grass. Position, sprite and state only move on
// frame_tick so a displayed frame never tears; start/catch/miss pulses are
// accepted on any cycle while idle or hidden and ignored while busy.
//
// Optional build macro: DOG_LAUGH_BOB_EN -- while the laughing dog holds at
// the apex its y bobs between apex and apex+2 every FRAMES_PER_STEP ticks.
//
// Ports:
//   clk          in   clock
//   rst          in   asynchronous active-high reset
//   frame_tick   in   one-cycle pulse per frame
//   start_intro  in   begin intro sequence
//   duck_caught  in   show dog holding duck (at catch_x)
//   duck_missed  in   show laughing dog
//   catch_x      in   x position for the catch pop-up
//   dog_select   out  sprite index to dog ROM
//   dog_xpos     out  sprite top-left x
//   dog_ypos     out  sprite top-left y
//   dog_visible  out  draw enable
//   busy         out  sequence in progress
//   intro_done   out  one-cycle pulse at end of intro
//   popup_done   out  one-cycle pulse at end of pop-up
// -----------------------------------------------------------------------------
module dog_ctl
    import dog_pkg::*;
#(
    parameter int WALK_START_X    = 0,
    parameter int SNIFF_X         = 200,
    parameter int WALK_END_X      = 350,
    parameter int GROUND_Y        = 600,
    parameter int HIDE_Y          = 560,
    parameter int JUMP_HEIGHT     = 80,
    parameter int POP_HEIGHT      = 48,
    parameter int WALK_SPEED      = 2,
    parameter int MOVE_SPEED      = 4,
    parameter int FRAMES_PER_STEP = 6,
    parameter int SNIFF_FRAMES    = 30,
    parameter int HOLD_FRAMES     = 60
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             frame_tick,
    input  logic             start_intro,
    input  logic             duck_caught,
    input  logic             duck_missed,
    input  logic [10:0]      catch_x,
    output logic [3:0]       dog_select,
    output logic [10:0]      dog_xpos,
    output logic [10:0]      dog_ypos,
    output logic             dog_visible,
    output logic             busy,
    output logic             intro_done,
    output logic             popup_done
);

    // One extra bit on sums so threshold compares see overshoot instead of wrap.
    localparam int EXT_W = POS_W + 1;

    localparam logic [POS_W-1:0] X_START     = POS_W'(WALK_START_X);
    localparam logic [POS_W-1:0] X_END       = POS_W'(WALK_END_X);
    localparam logic [EXT_W-1:0] X_SNIFF_E   = EXT_W'(SNIFF_X);
    localparam logic [EXT_W-1:0] X_END_E     = EXT_W'(WALK_END_X);
    localparam logic [EXT_W-1:0] X_SPEED_E   = EXT_W'(WALK_SPEED);
    localparam logic [POS_W-1:0] Y_GROUND    = POS_W'(GROUND_Y);
    localparam logic [POS_W-1:0] Y_HIDE      = POS_W'(HIDE_Y);
    localparam logic [EXT_W-1:0] Y_HIDE_E    = EXT_W'(HIDE_Y);
    localparam logic [POS_W-1:0] Y_JUMP_APEX = POS_W'(GROUND_Y - JUMP_HEIGHT);
    localparam logic [POS_W-1:0] Y_POP_APEX  = POS_W'(HIDE_Y - POP_HEIGHT);
    localparam logic [POS_W-1:0] Y_SPEED     = POS_W'(MOVE_SPEED);
    localparam logic [EXT_W-1:0] Y_SPEED_E   = EXT_W'(MOVE_SPEED);
`ifdef DOG_LAUGH_BOB_EN
    localparam logic [POS_W-1:0] Y_POP_BOB   = POS_W'(HIDE_Y - POP_HEIGHT + 2);
`endif

    dog_state_t       state_reg, state_next;
    logic [POS_W-1:0] x_reg, x_next;
    logic [POS_W-1:0] y_reg, y_next;
    logic [SEL_W-1:0] sel_reg, sel_next;
    logic             vis_reg, vis_next;
    logic             busy_reg, busy_next;
    logic             intro_done_reg, intro_done_next;
    logic             popup_done_reg, popup_done_next;
    logic             sniffed_reg, sniffed_next;
    logic             laugh_reg, laugh_next;

    logic [EXT_W-1:0] x_walk_e;
    logic [EXT_W-1:0] y_down_e;
    logic [POS_W-1:0] y_up;

    logic [N_CNT-1:0] cnt_tick;
    logic [N_CNT-1:0] cnt_clr;
    logic [N_CNT-1:0] cnt_hit;

    // -------------------------------------------------------------------------
    // Frame-tick timing counters: step (walk sprite / laugh bob), sniff, hold.
    // Every counter restarts whenever the state changes, so each phase counts
    // from zero on entry.
    // -------------------------------------------------------------------------
    assign cnt_tick[CNT_STEP]  = frame_tick & ((state_reg == ST_WALK) |
                                               ((state_reg == ST_HOLD) & laugh_reg));
    assign cnt_tick[CNT_SNIFF] = frame_tick & (state_reg == ST_SNIFF);
    assign cnt_tick[CNT_HOLD]  = frame_tick & (state_reg == ST_HOLD);

    genvar gi;
    generate
        for (gi = 0; gi < N_CNT; gi++) begin : g_cnt
            localparam int TERM = (gi == CNT_STEP)  ? FRAMES_PER_STEP :
                                  (gi == CNT_SNIFF) ? SNIFF_FRAMES    : HOLD_FRAMES;

            assign cnt_clr[gi] = (state_next != state_reg);

            dog_tick_cnt #(
                .WIDTH (CNT_W),
                .TERM  (TERM)
            ) u_cnt (
                .clk  (clk),
                .rst  (rst),
                .clr  (cnt_clr[gi]),
                .tick (cnt_tick[gi]),
                .hit  (cnt_hit[gi])
            );
        end
    endgenerate

    // -------------------------------------------------------------------------
    // Movement arithmetic with clamps: rising saturates at 0, sums are widened.
    // -------------------------------------------------------------------------
    assign x_walk_e = {1'b0, x_reg} + X_SPEED_E;
    assign y_down_e = {1'b0, y_reg} + Y_SPEED_E;
    assign y_up     = (y_reg >= Y_SPEED) ? (y_reg - Y_SPEED) : '0;

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= ST_IDLE;
            x_reg          <= X_START;
            y_reg          <= Y_GROUND;
            sel_reg        <= DOG_WALK0;
            vis_reg        <= 1'b0;
            busy_reg       <= 1'b0;
            intro_done_reg <= 1'b0;
            popup_done_reg <= 1'b0;
            sniffed_reg    <= 1'b0;
            laugh_reg      <= 1'b0;
        end else begin
            state_reg      <= state_next;
            x_reg          <= x_next;
            y_reg          <= y_next;
            sel_reg        <= sel_next;
            vis_reg        <= vis_next;
            busy_reg       <= busy_next;
            intro_done_reg <= intro_done_next;
            popup_done_reg <= popup_done_next;
            sniffed_reg    <= sniffed_next;
            laugh_reg      <= laugh_next;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state and output logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_next      = state_reg;
        x_next          = x_reg;
        y_next          = y_reg;
        sel_next        = sel_reg;
        vis_next        = vis_reg;
        intro_done_next = 1'b0;
        popup_done_next = 1'b0;
        sniffed_next    = sniffed_reg;
        laugh_next      = laugh_reg;

        case (state_reg)
            ST_IDLE, ST_HIDDEN: begin
                if (start_intro) begin
                    state_next   = ST_WALK;
                    x_next       = X_START;
                    y_next       = Y_GROUND;
                    sel_next     = DOG_WALK0;
                    vis_next     = 1'b1;
                    sniffed_next = 1'b0;
                end else if (duck_caught) begin
                    state_next = ST_CATCH_UP;
                    x_next     = catch_x;
                    y_next     = Y_HIDE;
                    sel_next   = DOG_HOLD;
                    vis_next   = 1'b1;
                    laugh_next = 1'b0;
                end else if (duck_missed) begin
                    state_next = ST_LAUGH_UP;
                    x_next     = X_END;
                    y_next     = Y_HIDE;
                    sel_next   = DOG_LAUGH;
                    vis_next   = 1'b1;
                    laugh_next = 1'b1;
                end
            end

            ST_WALK: begin
                if (frame_tick) begin
                    if (x_walk_e >= X_END_E) begin
                        state_next = ST_JUMP_UP;
                        x_next     = X_END;
                        sel_next   = DOG_JUMP_UP;
                    end else begin
                        x_next = x_walk_e[POS_W-1:0];
                        if (!sniffed_reg && (x_walk_e >= X_SNIFF_E)) begin
                            state_next   = ST_SNIFF;
                            sel_next     = DOG_SNIFF;
                            sniffed_next = 1'b1;
                        end else if (cnt_hit[CNT_STEP]) begin
                            sel_next = next_walk(sel_reg);
                        end
                    end
                end
            end

            ST_SNIFF: begin
                if (cnt_hit[CNT_SNIFF]) begin
                    state_next = ST_WALK;
                    sel_next   = DOG_WALK0;
                end
            end

            // The apex frame is still shown with the up sprite; the down
            // sprite takes over on the first descending tick.
            ST_JUMP_UP: begin
                if (frame_tick) begin
                    if (y_up <= Y_JUMP_APEX) begin
                        y_next     = Y_JUMP_APEX;
                        state_next = ST_JUMP_DOWN;
                    end else begin
                        y_next = y_up;
                    end
                end
            end

            ST_JUMP_DOWN: begin
                if (frame_tick) begin
                    sel_next = DOG_JUMP_DOWN;
                    if (y_down_e >= Y_HIDE_E) begin
                        y_next          = Y_HIDE;
                        state_next      = ST_HIDDEN;
                        vis_next        = 1'b0;
                        intro_done_next = 1'b1;
                    end else begin
                        y_next = y_down_e[POS_W-1:0];
                    end
                end
            end

            ST_CATCH_UP, ST_LAUGH_UP: begin
                if (frame_tick) begin
                    if (y_up <= Y_POP_APEX) begin
                        y_next     = Y_POP_APEX;
                        state_next = ST_HOLD;
                    end else begin
                        y_next = y_up;
                    end
                end
            end

            ST_HOLD: begin
                if (cnt_hit[CNT_HOLD]) begin
                    // Always descend from the apex so the drop length does
                    // not depend on the bob phase.
                    state_next = ST_DOWN;
                    y_next     = Y_POP_APEX;
                end
`ifdef DOG_LAUGH_BOB_EN
                else if (laugh_reg && cnt_hit[CNT_STEP]) begin
                    y_next = (y_reg == Y_POP_APEX) ? Y_POP_BOB : Y_POP_APEX;
                end
`endif
            end

            ST_DOWN: begin
                if (frame_tick) begin
                    if (y_down_e >= Y_HIDE_E) begin
                        y_next          = Y_HIDE;
                        state_next      = ST_HIDDEN;
                        vis_next        = 1'b0;
                        popup_done_next = 1'b1;
                    end else begin
                        y_next = y_down_e[POS_W-1:0];
                    end
                end
            end

            default: begin
                state_next = ST_IDLE;
                vis_next   = 1'b0;
            end
        endcase

        busy_next = (state_next != ST_IDLE) && (state_next != ST_HIDDEN);
    end

    assign dog_select  = sel_reg;
    assign dog_xpos    = x_reg;
    assign dog_ypos    = y_reg;
    assign dog_visible = vis_reg;
    assign busy        = busy_reg;
    assign intro_done  = intro_done_reg;
    assign popup_done  = popup_done_reg;

endmodule

// File: tb/tb_dog_ctl.sv
// -----------------------------------------------------------------------------
// tb_dog_ctl
// Self-checking bench for dog_ctl. Expected frames come from the sequence
// timeline (walk 2 px/tick, sprite step every 6 ticks, sniff at x=200 for 30
// ticks, jump to 520 and down to 560, pop-up 560->512 in 12 ticks, 60 held,
// 12 down). Each tick's expectation is queued before the tick is driven and
// popped for comparison once the outputs have updated.
// -----------------------------------------------------------------------------
module tb_dog_ctl;

    typedef struct packed {
        logic [3:0]  sel;
        logic [10:0] x;
        logic [10:0] y;
        logic        vis;
        logic        busy;
        logic        idone;
        logic        pdone;
    } obs_t;

`ifdef DOG_LAUGH_BOB_EN
    localparam bit BOB = 1'b1;
`else
    localparam bit BOB = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        frame_tick;
    logic        start_intro;
    logic        duck_caught;
    logic        duck_missed;
    logic [10:0] catch_x;
    logic [3:0]  dog_select;
    logic [10:0] dog_xpos;
    logic [10:0] dog_ypos;
    logic        dog_visible;
    logic        busy;
    logic        intro_done;
    logic        popup_done;

    int   n_tests;
    int   n_fail;
    obs_t exp_q[$];

    dog_ctl dut (
        .clk         (clk),
        .rst         (rst),
        .frame_tick  (frame_tick),
        .start_intro (start_intro),
        .duck_caught (duck_caught),
        .duck_missed (duck_missed),
        .catch_x     (catch_x),
        .dog_select  (dog_select),
        .dog_xpos    (dog_xpos),
        .dog_ypos    (dog_ypos),
        .dog_visible (dog_visible),
        .busy        (busy),
        .intro_done  (intro_done),
        .popup_done  (popup_done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic obs_t mk(int sel, int x, int y, bit vis, bit bsy, bit idn, bit pdn);
        obs_t o;
        o.sel   = 4'(sel);
        o.x     = 11'(x);
        o.y     = 11'(y);
        o.vis   = vis;
        o.busy  = bsy;
        o.idone = idn;
        o.pdone = pdn;
        return o;
    endfunction

    function automatic obs_t observe();
        return mk(int'(dog_select), int'(dog_xpos), int'(dog_ypos),
                  dog_visible, busy, intro_done, popup_done);
    endfunction

    function automatic string fmt(obs_t o);
        return $sformatf("sel=%0d x=%0d y=%0d vis=%b busy=%b idone=%b pdone=%b",
                         o.sel, o.x, o.y, o.vis, o.busy, o.idone, o.pdone);
    endfunction

    // Intro frame expected after the k-th frame tick following start_intro.
    function automatic obs_t intro_exp(int k);
        obs_t e;
        e = mk(0, 0, 600, 1'b1, 1'b1, 1'b0, 1'b0);
        if (k < 100) begin
            e.x = 11'(2 * k);
            e.sel = 4'((k / 6) % 4);
        end else if (k < 130) begin
            e.x = 11'd200;
            e.sel = 4'd4;
        end else if (k < 205) begin
            e.x = 11'(200 + 2 * (k - 130));
            e.sel = 4'(((k - 130) / 6) % 4);
        end else if (k <= 225) begin
            e.x = 11'd350;
            e.sel = 4'd5;
            e.y = 11'(600 - 4 * (k - 205));
        end else begin
            e.x = 11'd350;
            e.sel = 4'd6;
            e.y = 11'(520 + 4 * (k - 225));
            if (k >= 235) begin
                e.y = 11'd560;
                e.vis = 1'b0;
                e.busy = 1'b0;
                e.idone = 1'b1;
            end
        end
        return e;
    endfunction

    // Pop-up frame expected after the k-th frame tick following the trigger.
    function automatic obs_t popup_exp(int k, int px, int sel, bit bob);
        obs_t e;
        e = mk(sel, px, 560, 1'b1, 1'b1, 1'b0, 1'b0);
        if (k <= 12) begin
            e.y = 11'(560 - 4 * k);
        end else if (k < 72) begin
            e.y = (bob && (((k - 12) / 6) % 2 == 1)) ? 11'd514 : 11'd512;
        end else if (k < 84) begin
            e.y = 11'(512 + 4 * (k - 72));
        end else begin
            e.y = 11'd560;
            e.vis = 1'b0;
            e.busy = 1'b0;
            e.pdone = 1'b1;
        end
        return e;
    endfunction

    // One frame: tick pulse, sample just after the update and one clk later,
    // then idle so ticks are 10 clk apart.
    task automatic frame(output obs_t o, output obs_t o1);
        @(negedge clk);
        frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
        o = observe();
        @(negedge clk);
        o1 = observe();
        repeat (7) @(negedge clk);
    endtask

    task automatic pulse(bit si, bit dc, bit dm, int cx);
        @(negedge clk);
        start_intro = si;
        duck_caught = dc;
        duck_missed = dm;
        catch_x     = 11'(cx);
        @(negedge clk);
        start_intro = 1'b0;
        duck_caught = 1'b0;
        duck_missed = 1'b0;
    endtask

    task automatic test_reset();
        obs_t o, o1, e;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        o = observe();
        e = mk(0, 0, 600, 1'b0, 1'b0, 1'b0, 1'b0);
        n_tests++;
        if (o !== e) begin
            n_fail++;
            $display("FAIL reset_state: got %s, want %s", fmt(o), fmt(e));
        end
        rst = 1'b0;
        for (int k = 1; k <= 2; k++) begin
            exp_q.push_back(e);
            frame(o, o1);
            e = exp_q.pop_front();
            n_tests++;
            if (o !== e || o1 !== e) begin
                n_fail++;
                $display("FAIL idle_tick%0d: got %s / %s, want %s", k, fmt(o), fmt(o1), fmt(e));
            end
            $display("[TB] idle tick %0d %s", k, fmt(o));
        end
    endtask

    task automatic run_intro(string name, int last_tick);
        obs_t o, o1, e, e1;
        pulse(1'b1, 1'b0, 1'b0, 0);
        o = observe();
        e = mk(0, 0, 600, 1'b1, 1'b1, 1'b0, 1'b0);
        n_tests++;
        if (o !== e) begin
            n_fail++;
            $display("FAIL %s_start: got %s, want %s", name, fmt(o), fmt(e));
        end
        for (int k = 1; k <= last_tick; k++) begin
            exp_q.push_back(intro_exp(k));
            frame(o, o1);
            e = exp_q.pop_front();
            e1 = e;
            e1.idone = 1'b0;
            e1.pdone = 1'b0;
            n_tests++;
            if (o !== e || o1 !== e1) begin
                n_fail++;
                $display("FAIL %s_tick%0d: got %s / next %s, want %s / next %s",
                         name, k, fmt(o), fmt(o1), fmt(e), fmt(e1));
            end
            $display("[TB] %s tick %0d %s", name, k, fmt(o));
        end
    endtask

    task automatic test_intro();
        run_intro("intro", 235);
    endtask

    task automatic run_popup(string name, int px, int sel, bit bob, bit poke_busy);
        obs_t o, o1, e, e1;
        o = observe();
        e = mk(sel, px, 560, 1'b1, 1'b1, 1'b0, 1'b0);
        n_tests++;
        if (o !== e) begin
            n_fail++;
            $display("FAIL %s_start: got %s, want %s", name, fmt(o), fmt(e));
        end
        for (int k = 1; k <= 84; k++) begin
            exp_q.push_back(popup_exp(k, px, sel, bob));
            frame(o, o1);
            e = exp_q.pop_front();
            e1 = e;
            e1.idone = 1'b0;
            e1.pdone = 1'b0;
            n_tests++;
            if (o !== e || o1 !== e1) begin
                n_fail++;
                $display("FAIL %s_tick%0d: got %s / next %s, want %s / next %s",
                         name, k, fmt(o), fmt(o1), fmt(e), fmt(e1));
            end
            $display("[TB] %s tick %0d %s", name, k, fmt(o));
            // Pulses during the hold must be dropped, not queued.
            if (poke_busy && k == 40) pulse(1'b1, 1'b0, 1'b1, 5);
        end
        for (int k = 1; k <= 3; k++) begin
            frame(o, o1);
            n_tests++;
            if (o.pdone !== 1'b0 || o1.pdone !== 1'b0 || o.vis !== 1'b0 || o.busy !== 1'b0) begin
                n_fail++;
                $display("FAIL %s_after%0d: got %s, want vis=0 busy=0 pdone=0", name, k, fmt(o));
            end
            $display("[TB] %s hidden tick %0d %s", name, k, fmt(o));
        end
    endtask

    task automatic test_catch();
        // Caught and missed together: catch has priority.
        pulse(1'b0, 1'b1, 1'b1, 412);
        run_popup("catch", 412, 7, 1'b0, 1'b1);
    endtask

    task automatic test_laugh();
        pulse(1'b0, 1'b0, 1'b1, 0);
        run_popup("laugh", 350, 8, BOB, 1'b0);
    endtask

    task automatic test_async_reset();
        obs_t o, e;
        run_intro("prejump", 210);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        o = observe();
        e = mk(0, 0, 600, 1'b0, 1'b0, 1'b0, 1'b0);
        n_tests++;
        if (o !== e) begin
            n_fail++;
            $display("FAIL async_reset: got %s, want %s", fmt(o), fmt(e));
        end
        $display("[TB] async reset %s", fmt(o));
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        run_intro("restart", 110);
    endtask

    initial begin
        n_tests     = 0;
        n_fail      = 0;
        rst         = 1'b1;
        frame_tick  = 1'b0;
        start_intro = 1'b0;
        duck_caught = 1'b0;
        duck_missed = 1'b0;
        catch_x     = 11'd0;

        test_reset();
        test_intro();
        test_catch();
        test_laugh();
        test_async_reset();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/dog_ctl.md
Name: dog_ctl

Overview:
- Sequences the hunting-dog sprite for each round.
- Drives the 4-bit sprite index consumed by the dog ROM, plus the sprite top-left position and a visibility flag for the dog draw stage.
- Runs the intro walk/sniff/jump sequence, then the catch and laugh pop-ups behind the grass.
- Advances only on the per-frame tick, so sprite index and position stay constant within a displayed frame.

Parameters:
WALK_START_X, 0, x at intro start
SNIFF_X, 200, x where walk pauses to sniff
WALK_END_X, 350, x where jump starts
GROUND_Y, 600, y of walking dog
HIDE_Y, 560, y at which dog is fully behind grass
JUMP_HEIGHT, 80, rise above GROUND_Y during jump
POP_HEIGHT, 48, rise above HIDE_Y during pop-up
WALK_SPEED, 2, px per frame_tick while walking
MOVE_SPEED, 4, px per frame_tick for jump/pop
FRAMES_PER_STEP, 6, frame_ticks per walk-sprite advance
SNIFF_FRAMES, 30, frame_ticks spent sniffing
HOLD_FRAMES, 60, frame_ticks at pop-up apex

Ports:
clk  in  1  system/pixel clock
rst  in  1  asynchronous active-high reset
frame_tick  in  1  one-cycle pulse per frame (start of vblank)
start_intro  in  1  one-cycle pulse: begin intro
duck_caught  in  1  one-cycle pulse: show dog holding duck
duck_missed  in  1  one-cycle pulse: show laughing dog
catch_x  in  11  x position for catch pop-up, sampled with duck_caught
dog_select  out  4  sprite index to dog ROM
dog_xpos  out  11  sprite top-left x
dog_ypos  out  11  sprite top-left y
dog_visible  out  1  draw enable
busy  out  1  sequence in progress
intro_done  out  1  one-cycle pulse when jump completes
popup_done  out  1  one-cycle pulse when pop-up returns below grass

Behaviour:
- Clock is clk; reset rst is asynchronous and active-high.
- Reset values: state IDLE; dog_select 0; dog_xpos WALK_START_X; dog_ypos GROUND_Y; dog_visible 0; busy 0; intro_done 0; popup_done 0; all counters 0.
- All outputs are registered.
- Position, sprite and state advance only in the cycle where frame_tick=1; updates are visible on the following cycle.
- Control pulses are evaluated every cycle.
- Sprite map: 0-3 walk cycle, 4 sniff, 5 jump up, 6 jump down, 7 holding duck, 8 laughing.
- IDLE / HIDDEN, dog_visible=0, busy=0:
  - start_intro -> WALK, x=WALK_START_X, y=GROUND_Y, select 0.
  - Otherwise duck_caught -> CATCH_UP, x=catch_x, y=HIDE_Y, select 7.
  - Otherwise duck_missed -> LAUGH_UP, x=WALK_END_X, y=HIDE_Y, select 8.
  - Priority: start_intro > duck_caught > duck_missed.
- Any pulse while busy=1 is ignored, not queued.
- WALK, visible:
  - Per tick: x += WALK_SPEED. Step counter advances select 0->1->2->3->0 every FRAMES_PER_STEP ticks.
  - x >= SNIFF_X on first pass -> SNIFF. A sniffed flag prevents re-entry.
  - x >= WALK_END_X -> JUMP_UP. x is clamped to the threshold on overshoot.
- SNIFF: select 4 for SNIFF_FRAMES ticks, then back to WALK with step counter cleared.
- JUMP_UP: select 5; y -= MOVE_SPEED per tick until y <= GROUND_Y-JUMP_HEIGHT, then JUMP_DOWN.
- JUMP_DOWN: select 6; y += MOVE_SPEED per tick until y >= HIDE_Y.
  - Then HIDDEN: visible=0, intro_done pulse for one clk cycle.
  - Dog stays visible while rising/falling; the draw stage overlays grass.
- CATCH_UP / LAUGH_UP: y -= MOVE_SPEED per tick until y <= HIDE_Y-POP_HEIGHT (clamped), then HOLD.
- HOLD: HOLD_FRAMES ticks, then DOWN.
- DOWN: y += MOVE_SPEED per tick until y >= HIDE_Y (clamped), then HIDDEN with popup_done pulse.
- Arithmetic: 11-bit unsigned; clamps prevent wrap below 0 or overshoot.
- busy=1 in every state except IDLE and HIDDEN.
- rst mid-sequence returns to reset values immediately.

Optional Feature:
- Macro: DOG_LAUGH_BOB_EN.
- Defined: during LAUGH hold, dog_ypos toggles between apex and apex+2 every FRAMES_PER_STEP ticks.
- Undefined: laugh hold is static like catch hold.
- popup_done timing is identical in both builds.

Decomposition:
- Shared package dog_pkg:
  - state enum
  - sprite index constants: DOG_WALK0..3, DOG_SNIFF, DOG_JUMP_UP, DOG_JUMP_DOWN, DOG_HOLD, DOG_LAUGH
  - position width constant
- Sub-module dog_tick_cnt: frame_tick-driven counter with synchronous clear and terminal-count compare. Used for step, sniff and hold timing.

Test Plan:
- Reset, then start_intro with tick every 10 clk -> dog_select 0,1,2,3 every 6 ticks; x increments by 2 per tick; SNIFF at x=200 for 30 ticks with select 4.
- Intro run to completion -> JUMP_UP apex y=520 with select 5; select 6 on descent; intro_done single pulse at y=560; dog_visible falls.
- duck_caught with catch_x=412 in HIDDEN -> x=412, select 7, y 560->512 in 12 ticks, held 60 ticks, returns to 560, popup_done pulse.
- duck_caught and duck_missed in same cycle -> catch sequence (select 7); later duck_missed while busy -> ignored, no second popup_done.
- rst asserted mid-JUMP_UP asynchronously -> outputs immediately at reset values; next start_intro restarts from x=0.
- DOG_LAUGH_BOB_EN defined, duck_missed -> apex y alternates 512/514 every 6 ticks; undefined -> constant 512.
